// File: rtl/alu_sequencer.sv
// alu_sequencer: issues (opcode, A, B) entries from a small program memory to a registered ALU,
// waits out the ALU latency, then captures alu_out with a one-cycle res_valid strobe.
module alu_sequencer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned LAT   = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [19:0]   prog_data,
  input  logic          start,
  input  logic [AW:0]   count,
  output logic [3:0]    opcode,
  output logic [7:0]    A,
  output logic [7:0]    B,
  input  logic [7:0]    alu_out,
  output logic          busy,
  output logic          res_valid,
  output logic [7:0]    res_data,
  output logic [AW-1:0] res_idx,
  output logic          done
);

  localparam int unsigned WW = (LAT < 2) ? 1 : $clog2(LAT + 1);
  localparam logic [AW:0]   DepthCnt = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CntOne   = (AW + 1)'(1);
  localparam logic [AW-1:0] IdxOne   = AW'(1);
  localparam logic [WW-1:0] WaitOne  = WW'(1);
  localparam logic [WW-1:0] WaitLat  = WW'(LAT);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StCapture} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [3:0]    opcode_q, opcode_d;
  logic [7:0]    a_q, a_d;
  logic [7:0]    b_q, b_d;
  logic          busy_q, busy_d;
  logic          res_valid_q, res_valid_d;
  logic [7:0]    res_data_q, res_data_d;
  logic [AW-1:0] res_idx_q, res_idx_d;
  logic          done_q, done_d;

  logic [19:0]   mem_q [DEPTH];
  logic [19:0]   entry;
  logic [AW:0]   cnt_clamp;

  // Program memory: writable only while idle, deliberately not reset.
  always_ff @(posedge clk) begin
    if (prog_we && (state_q == StIdle)) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  // Next-state and registered-output computation for the issue/wait/capture sequence.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    opcode_d    = opcode_q;
    a_d         = a_q;
    b_d         = b_q;
    busy_d      = busy_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    res_idx_d   = res_idx_q;
    done_d      = 1'b0;
    entry       = mem_q[idx_q];
    cnt_clamp   = (count > DepthCnt) ? DepthCnt : count;

    unique case (state_q)
      StIdle: begin
        if (busy_q) begin
          // Trailing cycle of an empty (count=0) run; start is ignored here.
          busy_d = 1'b0;
        end else if (start) begin
          cnt_d  = cnt_clamp;
          idx_d  = '0;
          busy_d = 1'b1;
          if (cnt_clamp == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        opcode_d = entry[19:16];
        a_d      = entry[15:8];
        b_d      = entry[7:0];
        wait_d   = WaitLat;
        state_d  = StWait;
      end
      StWait: begin
        wait_d = wait_q - WaitOne;
        if (wait_q <= WaitOne) begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        res_data_d  = alu_out;
        res_idx_d   = idx_q;
        res_valid_d = 1'b1;
        if ({1'b0, idx_q} == (cnt_q - CntOne)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          idx_d   = idx_q + IdxOne;
          state_d = StIssue;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset aborts any run immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      cnt_q       <= '0;
      wait_q      <= '0;
      opcode_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_idx_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      opcode_q    <= opcode_d;
      a_q         <= a_d;
      b_q         <= b_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_idx_q   <= res_idx_d;
      done_q      <= done_d;
    end
  end

  assign opcode    = opcode_q;
  assign A         = a_q;
  assign B         = b_q;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_idx   = res_idx_q;
  assign done      = done_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a registered ALU model feeds alu_out; expected results (value, index,
// last flag, capture cycle) are queued at start time and checked by a monitor as results appear.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [19:0] prog_data = '0;
  logic        start = 1'b0;
  logic [4:0]  count = '0;
  logic [3:0]  op_w;
  logic [7:0]  a_w, b_w;
  logic [7:0]  alu_q = '0;
  logic        busy, res_valid, done;
  logic [7:0]  res_data;
  logic [3:0]  res_idx;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] data;
    logic [3:0] idx;
    logic       last;
    int         cyc;
  } exp_t;

  exp_t        sb[$];
  logic [19:0] prog [16];

  alu_sequencer #(.DEPTH(16), .AW(4), .LAT(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .start     (start),
    .count     (count),
    .opcode    (op_w),
    .A         (a_w),
    .B         (b_w),
    .alu_out   (alu_q),
    .busy      (busy),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_idx   (res_idx),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                       input logic [7:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      default: return ~a;
    endcase
  endfunction

  // Registered ALU: one edge of latency from operands to alu_out.
  always @(posedge clk) alu_q <= alu_f(op_w, a_w, b_w);

  task automatic write_entry(input logic [3:0] addr, input logic [19:0] data);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = addr; prog_data = data;
    @(negedge clk);
    prog_we = 1'b0;
    prog[addr] = data;
  endtask

  // Pulses start for one edge; e is the cycle number of the accepting edge.
  task automatic kick(input logic [4:0] c, output int e);
    @(negedge clk);
    start = 1'b1; count = c; e = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_run(input int n, input int e);
    exp_t x;
    for (int k = 0; k < n; k++) begin
      x.data = alu_f(prog[k][19:16], prog[k][15:8], prog[k][7:0]);
      x.idx  = 4'(k);
      x.last = (k == n - 1);
      x.cyc  = e + 3 + 3 * k;
      sb.push_back(x);
    end
  endtask

  task automatic wait_drain(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic monitor();
    exp_t x;
    forever begin
      @(negedge clk);
      if (rst_n && res_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got res_idx=%0d res_data=%h at cycle %0d, required none",
                   res_idx, res_data, cyc);
        end else begin
          x = sb.pop_front();
          checks++;
          if (res_data !== x.data) begin
            errors++;
            $display("FAIL res_data[%0d]: got %h, required %h", x.idx, res_data, x.data);
          end
          checks++;
          if (res_idx !== x.idx) begin
            errors++;
            $display("FAIL res_idx: got %0d, required %0d", res_idx, x.idx);
          end
          checks++;
          if (done !== x.last) begin
            errors++;
            $display("FAIL done_with_idx%0d: got %b, required %b", x.idx, done, x.last);
          end
          checks++;
          if (cyc !== x.cyc) begin
            errors++;
            $display("FAIL result_cycle[%0d]: got %0d, required %0d", x.idx, cyc, x.cyc);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({op_w, a_w, b_w, busy, res_valid, res_data, res_idx, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got op=%h A=%h B=%h busy=%b rv=%b rd=%h ri=%h done=%b, required all 0",
               op_w, a_w, b_w, busy, res_valid, res_data, res_idx, done);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, res_valid, done} !== 3'b000) begin
      errors++;
      $display("FAIL after_release: got busy=%b rv=%b done=%b, required 000", busy, res_valid, done);
    end
  endtask

  task automatic test_single_add();
    int e;
    bit ok;
    write_entry(4'd0, {4'h0, 8'h05, 8'h03});
    kick(5'd1, e);
    push_run(1, e);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (busy !== (i < 3)) begin
        errors++;
        $display("FAIL single_busy_cycle%0d: got %b, required %b", i, busy, (i < 3));
      end
      if (i == 1) begin
        checks++;
        if ({op_w, a_w, b_w} !== {4'h0, 8'h05, 8'h03}) begin
          errors++;
          $display("FAIL single_operands: got %h/%h/%h, required 0/05/03", op_w, a_w, b_w);
        end
      end
      if (i == 3) begin
        checks++;
        if ({res_valid, done, res_data} !== {1'b1, 1'b1, 8'h08}) begin
          errors++;
          $display("FAIL single_result: got rv=%b done=%b data=%h, required 1 1 08",
                   res_valid, done, res_data);
        end
      end
    end
    wait_drain(10, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_multi();
    int e;
    bit ok;
    write_entry(4'd0, {4'h0, 8'h10, 8'h20});
    write_entry(4'd1, {4'h0, 8'hFF, 8'h02});
    write_entry(4'd2, {4'h0, 8'h80, 8'h80});
    kick(5'd3, e);
    push_run(3, e);
    wait_drain(20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL multi_drain: got %0d pending, required 0", sb.size());
    end
    checks++;
    if ({res_data, res_idx, res_valid} !== {8'h00, 4'd2, 1'b0}) begin
      errors++;
      $display("FAIL multi_hold: got data=%h idx=%0d rv=%b, required 00 2 0",
               res_data, res_idx, res_valid);
    end
  endtask

  task automatic test_count_limits();
    int e;
    bit ok;
    kick(5'd0, e);
    checks++;
    if ({done, busy, res_valid} !== 3'b110) begin
      errors++;
      $display("FAIL count0_pulse: got done=%b busy=%b rv=%b, required 1 1 0", done, busy, res_valid);
    end
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++;
      $display("FAIL count0_after: got done=%b busy=%b, required 0 0", done, busy);
    end
    checks++;
    if ({op_w, a_w, b_w} !== {4'h0, 8'h80, 8'h80}) begin
      errors++;
      $display("FAIL count0_operands: got %h/%h/%h, required 0/80/80", op_w, a_w, b_w);
    end
    for (int k = 0; k < 16; k++) begin
      write_entry(4'(k), {4'(k % 6), 8'(k * 17 + 3), 8'(k * 5 + 1)});
    end
    kick(5'd31, e);
    push_run(16, e);
    wait_drain(60, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL count31_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_ignored_inputs();
    int e;
    bit ok;
    kick(5'd4, e);
    push_run(4, e);
    // Stray start and program write while the run is in progress.
    start = 1'b1; count = 5'd1;
    prog_we = 1'b1; prog_addr = 4'd1; prog_data = 20'hF_AAAA;
    repeat (4) @(negedge clk);
    start = 1'b0; prog_we = 1'b0;
    wait_drain(20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ignored_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_back_to_back();
    int e, e2;
    bit ok;
    kick(5'd16, e);
    push_run(16, e);
    repeat (48) @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done_cycle: got %b, required 1", done);
    end
    start = 1'b1; count = 5'd2; e2 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    push_run(2, e2);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart_busy: got %b, required 1", busy);
    end
    wait_drain(20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_reset_mid();
    int e;
    bit pulse = 1'b0;
    kick(5'd3, e);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({op_w, a_w, b_w, busy, res_valid, res_data, res_idx, done} !== '0) begin
      errors++;
      $display("FAIL midreset_clear: got op=%h A=%h B=%h busy=%b rd=%h ri=%h, required all 0",
               op_w, a_w, b_w, busy, res_data, res_idx);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (res_valid || done || busy) pulse = 1'b1;
    end
    checks++;
    if (pulse !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_pulse: got activity=%b, required 0", pulse);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single_add();
    test_multi();
    test_count_limits();
    test_ignored_inputs();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Instruction issuer for the ALU. Holds a small writable program of (opcode, A, B) entries, drives them onto the ALU's opcode/A/B inputs one at a time, waits out the ALU's registered latency, then captures ALU_Out into a result register with a valid strobe. It sits between the host/testbench and the ALU and is the producer side of the ALU operand interface.

## Interface
- DEPTH, 16: number of program entries (power of two).
- AW, 4: program address width, log2(DEPTH).
- LAT, 1: clock edges from operands becoming stable to alu_out holding the result. The ALU's registered output gives 1.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- prog_we  in  1  program write enable.
- prog_addr  in  AW  program write address.
- prog_data  in  20  entry {opcode[19:16], A[15:8], B[7:0]}.
- start  in  1  begin executing the program from entry 0.
- count  in  AW+1  number of entries to run. Sampled with start.
- opcode  out  4  to ALU opcode.
- A  out  8  to ALU A.
- B  out  8  to ALU B.
- alu_out  in  8  from ALU ALU_Out.
- busy  out  1  high from the start edge until completion.
- res_valid  out  1  one-cycle pulse; res_data/res_idx valid.
- res_data  out  8  captured ALU result.
- res_idx  out  AW  program index of res_data.
- done  out  1  one-cycle pulse at program completion.

## Operation
- States: IDLE, ISSUE, WAIT, CAPTURE.
- Program memory:
  - DEPTH x 20 register array, not reset.
  - Written on a clk edge when prog_we=1 and state=IDLE.
  - prog_we in any other state is ignored.
- IDLE:
  - With start=1: latch cnt = min(count, DEPTH), set idx=0, assert busy, go to ISSUE.
  - If the latched cnt=0: go straight to IDLE, pulse done, drop busy on the next edge. No ALU traffic.
- ISSUE: load opcode/A/B registers from mem[idx], load wait counter with LAT, go to WAIT.
- WAIT: decrement the wait counter each cycle. Go to CAPTURE when it reaches 1.
- CAPTURE:
  - res_data <= alu_out, res_idx <= idx, pulse res_valid.
  - If idx = cnt-1: pulse done, clear busy, go to IDLE.
  - Otherwise: idx <= idx+1, go to ISSUE.
- opcode/A/B hold their last issued values outside ISSUE. The ALU keeps computing on them; results are ignored except in CAPTURE.
- start while busy is ignored. count is only sampled in IDLE.
- No arithmetic is done here. alu_out is captured verbatim, 8 bits, with no sign or carry handling.

## Timing
- Reset (async, immediate): state=IDLE, idx=0, opcode=0, A=0, B=0, busy=0, res_valid=0, res_data=0, res_idx=0, done=0. Program memory is unchanged.
- Reset mid-program: abort at once. No res_valid or done follows.
- Start at edge e (LAT=1):
  - Operands change after e+1.
  - The ALU samples at e+2.
  - CAPTURE samples alu_out at e+3.
  - res_valid is high for the cycle after e+3.
- Per-entry period is LAT+2 cycles. Entry k's res_valid follows edge e+3+k*(LAT+2).
- done pulses in the same cycle as the last res_valid. busy falls at that same edge.
- The earliest next start is accepted at the following edge.
- res_valid and done are single-cycle pulses. res_data/res_idx hold until the next capture.

## Test plan
- Reset values: hold rst_n=0, then release. All outputs are 0 and busy=0. Assert rst_n=0 asynchronously mid-WAIT: outputs clear immediately and no res_valid follows.
- Single ADD: write entry 0 = {0000, 0x05, 0x03}, count=1, pulse start.
  - opcode=0, A=0x05, B=0x03 one cycle after start.
  - res_valid with res_data=0x08, res_idx=0 three cycles after start, coincident with done.
  - busy high for exactly 3 cycles.
- Multi-entry and wrap:
  - Write entries 0-2 = {0,0x10,0x20}, {0,0xFF,0x02}, {0,0x80,0x80}, count=3.
  - Expect res_data 0x30, 0x01, 0x00 at idx 0, 1, 2, spaced 3 cycles apart.
  - done only with idx 2.
- count=0: start produces a done pulse on the next cycle, with no res_valid and opcode/A/B unchanged. count=31 clamps to 16 and produces 16 results.
- Ignored inputs while busy:
  - A start pulse mid-run does not restart (idx keeps advancing).
  - prog_we to entry 1 during the run leaves entry 1's later result unchanged.
- Full depth with back-to-back programs: run all 16 entries, then assert start on the cycle after done. The second run begins and its first res_valid arrives 3 cycles after that start.
